hart_mem_arbiter: RTL and testbench

//  Shares one unified, variable-latency memory port between the hart's instruction-fetch

---
 rtl/hart_mem_arb_pkg.sv | 26 ++
 rtl/hart_mem_arb_timer.sv | 37 +++
 rtl/hart_mem_arbiter.sv | 154 +++++++++++++++
 tb/tb_hart_mem_arbiter.sv | 432 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hart_mem_arb_pkg.sv
// Shared types for the hart memory arbiter:
// FSM states, transaction owner and the latched request bundle.
package hart_mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_WAIT  = 2'd2,
    ST_FLUSH = 2'd3
  } arb_state_e;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_e;

  localparam logic [3:0] FETCH_MASK = 4'b1111;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  mask;
    logic        wen;
  } mem_req_t;

endpackage

// File: rtl/hart_mem_arb_timer.sv
// Loadable saturating cycle counter; o_hit flags the limit.
// A LIMIT of zero never hits.
module hart_mem_arb_timer #(
  parameter int unsigned LIMIT = 255
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clr,
  input  logic i_inc,
  output logic o_hit
);

  localparam int W = (LIMIT < 2) ? 1 : $clog2(LIMIT + 1);
  localparam logic [W-1:0] LIM = W'(LIMIT);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (i_clr) begin
      cnt_d = '0;
    end else if (i_inc && (cnt_q != '1)) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign o_hit = (LIMIT != 0) && (cnt_q == LIM);

endmodule

// File: rtl/hart_mem_arbiter.sv
// Shares one variable-latency memory port between fetch and load/store,
// one outstanding transaction, with a timeout error response.
module hart_mem_arbiter
  import hart_mem_arb_pkg::*;
#(
  parameter bit          DMEM_PRIORITY = 1'b1,
  parameter int unsigned TIMEOUT       = 255
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_ireq_valid,
  output logic        o_ireq_ready,
  input  logic [31:0] i_ireq_addr,
  output logic        o_iresp_valid,
  output logic        o_iresp_err,
  output logic [31:0] o_iresp_rdata,
  input  logic        i_dreq_valid,
  output logic        o_dreq_ready,
  input  logic [31:0] i_dreq_addr,
  input  logic        i_dreq_wen,
  input  logic [31:0] i_dreq_wdata,
  input  logic [3:0]  i_dreq_mask,
  output logic        o_dresp_valid,
  output logic        o_dresp_err,
  output logic [31:0] o_dresp_rdata,
  output logic        o_mem_valid,
  input  logic        i_mem_ready,
  output logic [31:0] o_mem_addr,
  output logic        o_mem_ren,
  output logic        o_mem_wen,
  output logic [31:0] o_mem_wdata,
  output logic [3:0]  o_mem_mask,
  input  logic        i_mem_rvalid,
  input  logic [31:0] i_mem_rdata
);

  arb_state_e state_q, state_d;
  owner_e     own_q, own_d;
  owner_e     last_q, last_d;
  mem_req_t   req_q, req_d;

  logic idle, pick_i, pick_d;
  logic in_req, resp_v, resp_err;
  logic t_clr, t_inc, t_hit;
  logic own_is_i, own_is_d;

  // readies are gated by reset so every output reads 0 while it is held
  assign idle   = (state_q == ST_IDLE) && i_rst_n;
  assign pick_d = i_dreq_valid &&
                  (!i_ireq_valid || DMEM_PRIORITY || (last_q == OWN_I));
  assign pick_i = i_ireq_valid && !pick_d;

  assign o_ireq_ready = idle && pick_i;
  assign o_dreq_ready = idle && pick_d;

  hart_mem_arb_timer #(
    .LIMIT(TIMEOUT)
  ) u_timer (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .i_clr  (t_clr),
    .i_inc  (t_inc),
    .o_hit  (t_hit)
  );

  always_comb begin
    state_d  = state_q;
    own_d    = own_q;
    last_d   = last_q;
    req_d    = req_q;
    t_clr    = 1'b0;
    t_inc    = 1'b0;
    resp_v   = 1'b0;
    resp_err = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (o_dreq_ready) begin
          req_d   = '{addr: i_dreq_addr, wdata: i_dreq_wdata,
                      mask: i_dreq_mask, wen: i_dreq_wen};
          own_d   = OWN_D;
          last_d  = OWN_D;
          state_d = ST_REQ;
        end else if (o_ireq_ready) begin
          req_d   = '{addr: i_ireq_addr, wdata: 32'h0,
                      mask: FETCH_MASK, wen: 1'b0};
          own_d   = OWN_I;
          last_d  = OWN_I;
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        if (i_mem_ready) begin
          t_clr   = 1'b1;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (i_mem_rvalid) begin
          resp_v  = 1'b1;
          state_d = ST_IDLE;
        end else if (t_hit) begin
          resp_v   = 1'b1;
          resp_err = 1'b1;
          t_clr    = 1'b1;
          state_d  = ST_FLUSH;
        end else begin
          t_inc = 1'b1;
        end
      end
      ST_FLUSH: begin
        // the late response is swallowed; no grant until it arrives or we give up
        if (i_mem_rvalid || t_hit) begin
          state_d = ST_IDLE;
        end else begin
          t_inc = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      own_q   <= OWN_I;
      last_q  <= OWN_I;
      req_q   <= '0;
    end else begin
      state_q <= state_d;
      own_q   <= own_d;
      last_q  <= last_d;
      req_q   <= req_d;
    end
  end

  assign in_req      = (state_q == ST_REQ);
  assign o_mem_valid = in_req;
  assign o_mem_addr  = in_req ? req_q.addr : 32'h0;
  assign o_mem_wdata = in_req ? req_q.wdata : 32'h0;
  assign o_mem_mask  = in_req ? req_q.mask : 4'h0;
  assign o_mem_ren   = in_req && !req_q.wen;
  assign o_mem_wen   = in_req && req_q.wen;

  assign own_is_i = (own_q == OWN_I);
  assign own_is_d = (own_q == OWN_D);

  assign o_iresp_valid = resp_v && own_is_i;
  assign o_iresp_err   = resp_err && own_is_i;
  assign o_iresp_rdata = (resp_v && !resp_err && own_is_i) ? i_mem_rdata : 32'h0;
  assign o_dresp_valid = resp_v && own_is_d;
  assign o_dresp_err   = resp_err && own_is_d;
  assign o_dresp_rdata = (resp_v && !resp_err && own_is_d) ? i_mem_rdata : 32'h0;

endmodule

// File: tb/tb_hart_mem_arbiter.sv
// Self-checking bench for hart_mem_arbiter: directed scenarios plus a
// randomized run against an ownership/latency reference model.
module tb_hart_mem_arbiter;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        iv, iready, irv, ierr;
  logic [31:0] iaddr, irdata;
  logic        dv, dready, dwen, drv, derr;
  logic [31:0] daddr, dwdata, drdata;
  logic [3:0]  dmask;
  logic        mvalid, mready, mren, mwen, mrvalid;
  logic [31:0] maddr, mwdata, mrdata;
  logic [3:0]  mmask;

  logic        r_iv, r_dv, r_iready, r_dready, r_irv, r_ierr, r_drv, r_derr;
  logic [31:0] r_irdata, r_drdata, r_maddr, r_mwdata;
  logic        r_mvalid, r_mren, r_mwen, r_mrvalid;
  logic [3:0]  r_mmask;

  logic [140:0] outs;
  assign outs = {iready, irv, ierr, irdata, dready, drv, derr, drdata,
                 mvalid, maddr, mren, mwen, mwdata, mmask};

  int n_cmp = 0;
  int n_bad = 0;

  hart_mem_arbiter #(.DMEM_PRIORITY(1'b1), .TIMEOUT(8)) u_dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_ireq_valid(iv), .o_ireq_ready(iready), .i_ireq_addr(iaddr),
    .o_iresp_valid(irv), .o_iresp_err(ierr), .o_iresp_rdata(irdata),
    .i_dreq_valid(dv), .o_dreq_ready(dready), .i_dreq_addr(daddr),
    .i_dreq_wen(dwen), .i_dreq_wdata(dwdata), .i_dreq_mask(dmask),
    .o_dresp_valid(drv), .o_dresp_err(derr), .o_dresp_rdata(drdata),
    .o_mem_valid(mvalid), .i_mem_ready(mready), .o_mem_addr(maddr),
    .o_mem_ren(mren), .o_mem_wen(mwen), .o_mem_wdata(mwdata),
    .o_mem_mask(mmask), .i_mem_rvalid(mrvalid), .i_mem_rdata(mrdata)
  );

  hart_mem_arbiter #(.DMEM_PRIORITY(1'b0), .TIMEOUT(8)) u_rr (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_ireq_valid(r_iv), .o_ireq_ready(r_iready), .i_ireq_addr(iaddr),
    .o_iresp_valid(r_irv), .o_iresp_err(r_ierr), .o_iresp_rdata(r_irdata),
    .i_dreq_valid(r_dv), .o_dreq_ready(r_dready), .i_dreq_addr(daddr),
    .i_dreq_wen(dwen), .i_dreq_wdata(dwdata), .i_dreq_mask(dmask),
    .o_dresp_valid(r_drv), .o_dresp_err(r_derr), .o_dresp_rdata(r_drdata),
    .o_mem_valid(r_mvalid), .i_mem_ready(1'b1), .o_mem_addr(r_maddr),
    .o_mem_ren(r_mren), .o_mem_wen(r_mwen), .o_mem_wdata(r_mwdata),
    .o_mem_mask(r_mmask), .i_mem_rvalid(r_mrvalid), .i_mem_rdata(mrdata)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    iv = 1'b1; dv = 1'b1; iaddr = 32'h10; daddr = 32'h20;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (outs !== '0) begin
      n_bad++; $display("FAIL reset_outs: got %h want 0", outs);
    end
    step();
    rst_n = 1'b1; iv = 1'b0; dv = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (outs !== '0) begin
      n_bad++; $display("FAIL idle_outs: got %h want 0", outs);
    end
  endtask

  task automatic test_fetch();
    step();
    iv = 1'b1; iaddr = 32'h100;
    @(negedge clk);
    n_cmp++;
    if ({iready, dready} !== 2'b10) begin
      n_bad++; $display("FAIL fetch_grant: got %b want 10", {iready, dready});
    end
    step();
    iv = 1'b0; iaddr = $urandom; mready = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({mvalid, maddr, mren, mwen, mmask} !== {1'b1, 32'h100, 2'b10, 4'hF}) begin
      n_bad++; $display("FAIL fetch_mem: got %b %h %b%b %h want 1 100 10 f",
                        mvalid, maddr, mren, mwen, mmask);
    end
    step();
    mready = 1'b0; mrvalid = 1'b1; mrdata = 32'h0050_0093;
    @(negedge clk);
    n_cmp++;
    if ({irv, ierr, irdata, drv} !== {2'b10, 32'h0050_0093, 1'b0}) begin
      n_bad++; $display("FAIL fetch_resp: got %b%b %h %b want 10 00500093 0",
                        irv, ierr, irdata, drv);
    end
    step();
    mrvalid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({irv, drv, mvalid} !== 3'b000) begin
      n_bad++; $display("FAIL fetch_after: got %b want 000", {irv, drv, mvalid});
    end
  endtask

  task automatic test_priority();
    logic [31:0] x;
    int gnt[$];
    int tg[$];
    bit nxt;
    step();
    iv = 1'b1; iaddr = 32'h0; dv = 1'b1; daddr = 32'h2000; dwen = 1'b0; dmask = 4'hF;
    @(negedge clk);
    n_cmp++;
    if ({iready, dready} !== 2'b01) begin
      n_bad++; $display("FAIL prio_grant: got %b want 01", {iready, dready});
    end
    step();
    dv = 1'b0; mready = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({maddr, mren, iready} !== {32'h2000, 2'b10}) begin
      n_bad++; $display("FAIL prio_mem: got %h %b %b want 2000 1 0", maddr, mren, iready);
    end
    step();
    mready = 1'b0; mrvalid = 1'b1; x = $urandom; mrdata = x;
    @(negedge clk);
    n_cmp++;
    if ({drv, derr, drdata, irv, iready} !== {2'b10, x, 2'b00}) begin
      n_bad++; $display("FAIL prio_dresp: got %b%b %h %b%b want 10 %h 00",
                        drv, derr, drdata, irv, iready, x);
    end
    step();
    mrvalid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (iready !== 1'b1) begin
      n_bad++; $display("FAIL prio_t3: got %b want 1", iready);
    end
    step();
    iv = 1'b0; mready = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({maddr, mmask} !== {32'h0, 4'hF}) begin
      n_bad++; $display("FAIL prio_imem: got %h %h want 0 f", maddr, mmask);
    end
    step();
    mready = 1'b0; mrvalid = 1'b1; x = $urandom; mrdata = x;
    @(negedge clk);
    n_cmp++;
    if ({irv, irdata, drv} !== {1'b1, x, 1'b0}) begin
      n_bad++; $display("FAIL prio_iresp: got %b %h %b want 1 %h 0", irv, irdata, drv, x);
    end
    step();
    mrvalid = 1'b0;
    r_iv = 1'b1; r_dv = 1'b1; nxt = 1'b0;
    for (int c = 0; c < 40 && gnt.size() < 4; c++) begin
      @(negedge clk);
      if (r_dready) begin gnt.push_back(1); tg.push_back(c); end
      else if (r_iready) begin gnt.push_back(0); tg.push_back(c); end
      nxt = r_mvalid;
      step();
      r_mrvalid = nxt;
    end
    r_iv = 1'b0; r_dv = 1'b0;
    repeat (4) begin
      @(negedge clk);
      nxt = r_mvalid;
      step();
      r_mrvalid = nxt;
    end
    n_cmp++;
    if (gnt.size() != 4) begin
      n_bad++; $display("FAIL rr_count: got %0d want 4", gnt.size());
    end
    for (int k = 0; k < 4 && k < gnt.size(); k++) begin
      n_cmp++;
      if (gnt[k] != ((k % 2 == 0) ? 1 : 0)) begin
        n_bad++; $display("FAIL rr_order%0d: got %0d want %0d", k, gnt[k], (k % 2 == 0) ? 1 : 0);
      end
      if (k > 0) begin
        n_cmp++;
        if (tg[k] - tg[k-1] != 3) begin
          n_bad++; $display("FAIL rr_gap%0d: got %0d want 3", k, tg[k] - tg[k-1]);
        end
      end
    end
  endtask

  task automatic test_store_stall();
    step();
    dv = 1'b1; dwen = 1'b1; daddr = 32'h2000; dwdata = 32'hAB00_0000; dmask = 4'b1000;
    @(negedge clk);
    n_cmp++;
    if (dready !== 1'b1) begin
      n_bad++; $display("FAIL st_grant: got %b want 1", dready);
    end
    step();
    dv = 1'b0; daddr = $urandom; dwdata = $urandom; dmask = 4'b0001; mready = 1'b0;
    for (int k = 0; k < 6; k++) begin
      if (k == 5) mready = 1'b1;
      @(negedge clk);
      n_cmp++;
      if ({mvalid, maddr, mwdata, mmask, mwen, mren} !==
          {1'b1, 32'h2000, 32'hAB00_0000, 4'b1000, 2'b10}) begin
        n_bad++; $display("FAIL st_hold%0d: got %b %h %h %b %b%b", k,
                          mvalid, maddr, mwdata, mmask, mwen, mren);
      end
      step();
    end
    mready = 1'b0; mrvalid = 1'b1; mrdata = $urandom;
    @(negedge clk);
    n_cmp++;
    if ({drv, derr, irv} !== 3'b100) begin
      n_bad++; $display("FAIL st_ack: got %b want 100", {drv, derr, irv});
    end
    step();
    mrvalid = 1'b0; dwen = 1'b0;
  endtask

  task automatic test_timeout();
    logic [31:0] x;
    step();
    dv = 1'b1; dwen = 1'b0; daddr = 32'h3000; dmask = 4'hF;
    @(negedge clk);
    n_cmp++;
    if (dready !== 1'b1) begin
      n_bad++; $display("FAIL to_grant: got %b want 1", dready);
    end
    step();
    dv = 1'b0; mready = 1'b1;
    @(negedge clk);
    step();
    mready = 1'b0;
    for (int k = 0; k <= 8; k++) begin
      @(negedge clk);
      n_cmp++;
      if (k < 8 && {drv, irv} !== 2'b00) begin
        n_bad++; $display("FAIL to_early%0d: got %b want 00", k, {drv, irv});
      end else if (k == 8 && {drv, derr, irv} !== 3'b110) begin
        n_bad++; $display("FAIL to_err: got %b want 110", {drv, derr, irv});
      end
      step();
    end
    for (int k = 0; k < 3; k++) begin
      if (k == 2) begin mrvalid = 1'b1; mrdata = 32'hDEAD_BEEF; end
      @(negedge clk);
      n_cmp++;
      if ({drv, irv} !== 2'b00) begin
        n_bad++; $display("FAIL to_flush%0d: got %b want 00", k, {drv, irv});
      end
      step();
    end
    mrvalid = 1'b0; iv = 1'b1; iaddr = 32'h40;
    @(negedge clk);
    n_cmp++;
    if ({iready, drv, irv} !== 3'b100) begin
      n_bad++; $display("FAIL to_next_grant: got %b want 100", {iready, drv, irv});
    end
    step();
    iv = 1'b0; mready = 1'b1;
    @(negedge clk);
    step();
    mready = 1'b0; mrvalid = 1'b1; x = $urandom; mrdata = x;
    @(negedge clk);
    n_cmp++;
    if ({irv, ierr, irdata, drv} !== {2'b10, x, 1'b0}) begin
      n_bad++; $display("FAIL to_next_resp: got %b%b %h %b want 10 %h 0",
                        irv, ierr, irdata, drv, x);
    end
    step();
    mrvalid = 1'b0;
  endtask

  task automatic test_reset_wait();
    logic [31:0] x;
    step();
    iv = 1'b1; iaddr = 32'h80;
    @(negedge clk);
    step();
    iv = 1'b0; mready = 1'b1;
    @(negedge clk);
    step();
    mready = 1'b0;
    @(negedge clk);
    #2;
    rst_n = 1'b0; iv = 1'b1; iaddr = 32'h4;
    #1;
    n_cmp++;
    if (outs !== '0) begin
      n_bad++; $display("FAIL rst_async: got %h want 0", outs);
    end
    step();
    mrvalid = 1'b1; mrdata = $urandom;
    @(negedge clk);
    n_cmp++;
    if (outs !== '0) begin
      n_bad++; $display("FAIL rst_noresp: got %h want 0", outs);
    end
    step();
    mrvalid = 1'b0; rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({iready, irv, drv} !== 3'b100) begin
      n_bad++; $display("FAIL rst_regrant: got %b want 100", {iready, irv, drv});
    end
    step();
    iv = 1'b0; mready = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({maddr, mren, mmask} !== {32'h4, 1'b1, 4'hF}) begin
      n_bad++; $display("FAIL rst_mem: got %h %b %h want 4 1 f", maddr, mren, mmask);
    end
    step();
    mready = 1'b0; mrvalid = 1'b1; x = $urandom; mrdata = x;
    @(negedge clk);
    n_cmp++;
    if ({irv, irdata, drv} !== {1'b1, x, 1'b0}) begin
      n_bad++; $display("FAIL rst_resp: got %b %h %b want 1 %h 0", irv, irdata, drv, x);
    end
    step();
    mrvalid = 1'b0;
  endtask

  task automatic test_random();
    bit ip = 0, dp = 0, busy = 0, rq = 0, acc = 0, b0, ei, ed, own_d = 0;
    int dly = 0, ngr = 0, nrs = 0;
    logic [31:0] ra = 0, rw = 0;
    logic [3:0] rm = 0;
    logic rwen = 0;
    for (int c = 0; c < 600; c++) begin
      step();
      if (c < 560) begin
        if (!ip && $urandom_range(0, 2) == 0) begin
          ip = 1; iaddr = $urandom & 32'hFFFF_FFFC;
        end else if (ip && $urandom_range(0, 15) == 0) begin
          ip = 0;
        end
        if (!dp && $urandom_range(0, 2) == 0) begin
          dp = 1; daddr = $urandom & 32'hFFFF_FFFC; dwen = 1'($urandom_range(0, 1));
          dwdata = $urandom; dmask = 4'($urandom_range(1, 15));
        end else if (dp && $urandom_range(0, 15) == 0) begin
          dp = 0;
        end
      end
      iv = ip; dv = dp;
      mready = 1'($urandom_range(0, 1));
      if (acc && dly == 0) begin
        mrvalid = 1'b1; mrdata = $urandom;
      end else begin
        mrvalid = 1'b0;
        if (acc) dly--;
      end
      @(negedge clk);
      b0 = busy;
      n_cmp++;
      if (rq) begin
        if ({mvalid, maddr, mren, mwen, mmask} !== {1'b1, ra, !rwen, rwen, rm}) begin
          n_bad++; $display("FAIL rnd_mem c%0d: got %b %h %b%b %h want 1 %h %b%b %h",
                            c, mvalid, maddr, mren, mwen, mmask, ra, !rwen, rwen, rm);
        end
        if (rwen) begin
          n_cmp++;
          if (mwdata !== rw) begin
            n_bad++; $display("FAIL rnd_wdata c%0d: got %h want %h", c, mwdata, rw);
          end
        end
        if (mready) begin rq = 0; acc = 1; dly = $urandom_range(0, 3); end
      end else if ({mvalid, mren, mwen} !== 3'b000) begin
        n_bad++; $display("FAIL rnd_memidle c%0d: got %b want 000", c, {mvalid, mren, mwen});
      end
      n_cmp++;
      if (mrvalid) begin
        acc = 0; busy = 0; nrs++;
        if (!own_d && {irv, ierr, irdata, drv} !== {2'b10, mrdata, 1'b0}) begin
          n_bad++; $display("FAIL rnd_iresp c%0d: got %b%b %h %b want 10 %h 0",
                            c, irv, ierr, irdata, drv, mrdata);
        end else if (own_d && !rwen && {drv, derr, drdata, irv} !== {2'b10, mrdata, 1'b0}) begin
          n_bad++; $display("FAIL rnd_dload c%0d: got %b%b %h %b want 10 %h 0",
                            c, drv, derr, drdata, irv, mrdata);
        end else if (own_d && rwen && {drv, derr, irv} !== 3'b100) begin
          n_bad++; $display("FAIL rnd_dstore c%0d: got %b want 100", c, {drv, derr, irv});
        end
      end else if ({irv, drv} !== 2'b00) begin
        n_bad++; $display("FAIL rnd_spurious c%0d: got %b want 00", c, {irv, drv});
      end
      ed = !b0 && dp;
      ei = !b0 && ip && !dp;
      n_cmp++;
      if ({iready, dready} !== {ei, ed}) begin
        n_bad++; $display("FAIL rnd_ready c%0d: got %b want %b", c, {iready, dready}, {ei, ed});
      end
      if (ed) begin
        ra = daddr; rw = dwdata; rm = dmask; rwen = dwen;
        own_d = 1; busy = 1; rq = 1; dp = 0; ngr++;
      end else if (ei) begin
        ra = iaddr; rm = 4'hF; rwen = 0;
        own_d = 0; busy = 1; rq = 1; ip = 0; ngr++;
      end
    end
    step();
    iv = 1'b0; dv = 1'b0; mready = 1'b0; mrvalid = 1'b0;
    n_cmp++;
    if (ngr != nrs || busy) begin
      n_bad++; $display("FAIL rnd_balance: got %0d grants %0d resps busy %0d", ngr, nrs, busy);
    end
  endtask

  initial begin
    iv = 0; dv = 0; iaddr = 0; daddr = 0; dwen = 0; dwdata = 0; dmask = 0;
    mready = 0; mrvalid = 0; mrdata = 0; r_iv = 0; r_dv = 0; r_mrvalid = 0;
    test_reset();
    test_fetch();
    test_priority();
    test_store_stall();
    test_timeout();
    test_random();
    test_reset_wait();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
